// File: rtl/fifo_serial_pkg.sv
// Shared encodings for the FIFO serial drain stage: FSM states and line levels.
package fifo_serial_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO-side handshake and serial-line signals of the drain stage.
interface fifo_serial_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             tx_en;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             tx;
    logic             busy;
    logic             frame_done;

    modport master (
        input  tx_en,
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd_en,
        output tx,
        output busy,
        output frame_done
    );

    modport slave (
        output tx_en,
        output fifo_data,
        output fifo_empty,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fifo_serial_tx.sv
// Drain stage: pops words from a show-ahead FIFO and sends each one as an async serial frame.
module fifo_serial_tx
    import fifo_serial_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             reset,
    fifo_serial_tx_if.master bus
);
    localparam int unsigned   BW        = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             tx_q, tx_d;
    logic             tick;
    logic             last_stop;
    logic             rd_en;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == StIdle),
        .tick  (tick)
    );

    assign last_stop = (state_q == StStop) && tick && (bit_cnt_q == LAST_STOP);
    // Gated by reset so a held reset never pops the FIFO.
    assign rd_en = !reset && bus.tx_en && !bus.fifo_empty && ((state_q == StIdle) || last_stop);

    assign bus.fifo_rd_en = rd_en;
    assign bus.tx         = tx_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.frame_done = last_stop;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        if (rd_en) begin
            state_d   = StStart;
            shift_d   = bus.fifo_data;
            parity_d  = ^bus.fifo_data;
            bit_cnt_d = '0;
        end else if (tick) begin
            case (state_q)
                StStart: begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
                StData: begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                StParity: begin
                    state_d   = StStop;
                    bit_cnt_d = '0;
                end
                StStop: begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = StIdle;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Line level is derived from the next state so tx changes on the same edge as the state.
    always_comb begin
        tx_d = TX_IDLE_LEVEL;
        case (state_d)
            StStart:  tx_d = START_LEVEL;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = TX_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= TX_IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: 8N1 instance plus an 8E2 instance for the parity case.
module tb_fifo_serial_tx;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_serial_tx_if #(.WIDTH(8)) bus ();
    fifo_serial_tx_if #(.WIDTH(8)) bus2 ();

    fifo_serial_tx #(
        .WIDTH        (8),
        .CLKS_PER_BIT (4),
        .PARITY_EN    (0),
        .STOP_BITS    (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fifo_serial_tx #(
        .WIDTH        (8),
        .CLKS_PER_BIT (4),
        .PARITY_EN    (1),
        .STOP_BITS    (2)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // Show-ahead FIFO models feeding each instance.
    logic [7:0] mem  [0:63];
    logic [7:0] mem2 [0:63];
    int wr_ptr = 0, rd_ptr = 0, wr2 = 0, rd2 = 0;
    int pops = 0, pops2 = 0, cyc = 0;
    int pop_cyc [16];
    int total = 0, bad = 0;

    assign bus.fifo_data   = mem[rd_ptr[5:0]];
    assign bus.fifo_empty  = (rd_ptr == wr_ptr);
    assign bus2.fifo_data  = mem2[rd2[5:0]];
    assign bus2.fifo_empty = (rd2 == wr2);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd_en) begin
            if (pops < 16) pop_cyc[pops] <= cyc;
            pops   <= pops + 1;
            rd_ptr <= rd_ptr + 1;
        end
        if (bus2.fifo_rd_en) begin
            pops2 <= pops2 + 1;
            rd2   <= rd2 + 1;
        end
    end

    task automatic test_reset();
        int n;
        reset = 1'b1;
        bus.tx_en = 1'b0;
        bus2.tx_en = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0 ||
            bus.frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state tx=%b busy=%b rd_en=%b done=%b expected 1 0 0 0",
                     bus.tx, bus.busy, bus.fifo_rd_en, bus.frame_done);
        end
        reset = 1'b0;
        bus.tx_en = 1'b1;
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL idle_empty bad_cycles=%0d expected 0", n);
        end
        total++;
        if (pops != 0) begin
            bad++;
            $display("FAIL idle_no_pop pops=%0d expected 0", pops);
        end
    endtask

    task automatic test_single();
        logic [9:0] fr;
        int p0;
        fr = 10'b11_0100_1010;  // A5 frame, bit 0 = start
        p0 = pops;
        mem[wr_ptr[5:0]] = 8'hA5;
        wr_ptr++;
        #1;
        total++;
        if (bus.fifo_rd_en !== 1'b1) begin
            bad++;
            $display("FAIL single_rd_en got=%b expected 1", bus.fifo_rd_en);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            total++;
            if (bus.tx !== fr[k/4] || bus.busy !== 1'b1 || bus.frame_done !== (k == 39) ||
                bus.fifo_rd_en !== 1'b0) begin
                bad++;
                $display("FAIL single_frame k=%0d tx=%b busy=%b done=%b rd=%b expected %b 1 %b 0",
                         k, bus.tx, bus.busy, bus.frame_done, bus.fifo_rd_en, fr[k/4], (k == 39));
            end
        end
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
            bad++;
            $display("FAIL single_end busy=%b tx=%b expected 0 1", bus.busy, bus.tx);
        end
        total++;
        if (pops - p0 != 1) begin
            bad++;
            $display("FAIL single_pops got=%0d expected 1", pops - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] fr [3];
        logic [9:0] cur;
        int first, dones;
        fr[0] = {1'b1, 8'h00, 1'b0};
        fr[1] = {1'b1, 8'hFF, 1'b0};
        fr[2] = {1'b1, 8'h3C, 1'b0};
        first = pops;
        dones = 0;
        mem[wr_ptr[5:0]] = 8'h00;
        mem[(wr_ptr + 1) % 64] = 8'hFF;
        mem[(wr_ptr + 2) % 64] = 8'h3C;
        wr_ptr += 3;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            cur = fr[k/40];
            if (bus.frame_done === 1'b1) dones++;
            total++;
            if (bus.tx !== cur[(k%40)/4] || bus.busy !== 1'b1 ||
                bus.fifo_rd_en !== (k == 39 || k == 79)) begin
                bad++;
                $display("FAIL b2b_frame k=%0d tx=%b busy=%b rd=%b expected %b 1 %b",
                         k, bus.tx, bus.busy, bus.fifo_rd_en, cur[(k%40)/4], (k == 39 || k == 79));
            end
        end
        @(negedge clk);
        total++;
        if (dones != 3 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done dones=%0d busy=%b expected 3 0", dones, bus.busy);
        end
        total++;
        if (pops - first != 3) begin
            bad++;
            $display("FAIL b2b_pops got=%0d expected 3", pops - first);
        end else begin
            total++;
            if (pop_cyc[first+1] - pop_cyc[first] != 40 ||
                pop_cyc[first+2] - pop_cyc[first+1] != 40) begin
                bad++;
                $display("FAIL b2b_spacing gaps=%0d,%0d expected 40,40",
                         pop_cyc[first+1] - pop_cyc[first], pop_cyc[first+2] - pop_cyc[first+1]);
            end
        end
    endtask

    task automatic test_parity();
        logic [11:0] fr;
        fr = 12'b1110_0000_1110;  // start, 07 LSB first, parity 1, two stops
        bus2.tx_en = 1'b1;
        mem2[wr2[5:0]] = 8'h07;
        wr2++;
        #1;
        total++;
        if (bus2.fifo_rd_en !== 1'b1) begin
            bad++;
            $display("FAIL parity_rd_en got=%b expected 1", bus2.fifo_rd_en);
        end
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            total++;
            if (bus2.tx !== fr[k/4] || bus2.busy !== 1'b1 || bus2.frame_done !== (k == 47)) begin
                bad++;
                $display("FAIL parity_frame k=%0d tx=%b busy=%b done=%b expected %b 1 %b",
                         k, bus2.tx, bus2.busy, bus2.frame_done, fr[k/4], (k == 47));
            end
        end
        @(negedge clk);
        total++;
        if (bus2.busy !== 1'b0 || bus2.tx !== 1'b1 || pops2 != 1) begin
            bad++;
            $display("FAIL parity_end busy=%b tx=%b pops=%0d expected 0 1 1",
                     bus2.busy, bus2.tx, pops2);
        end
    endtask

    task automatic test_tx_en_drop();
        logic [9:0] fr;
        int p0, n;
        fr = {1'b1, 8'h55, 1'b0};
        p0 = pops;
        mem[wr_ptr[5:0]] = 8'h55;
        mem[(wr_ptr + 1) % 64] = 8'h81;
        wr_ptr += 2;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 16) bus.tx_en = 1'b0;  // data bit 3
            total++;
            if (k < 40) begin
                if (bus.tx !== fr[k/4] || bus.busy !== 1'b1 || bus.fifo_rd_en !== 1'b0 ||
                    bus.frame_done !== (k == 39)) begin
                    bad++;
                    $display("FAIL en_drop_frame k=%0d tx=%b busy=%b rd=%b done=%b expected %b 1 0 %b",
                             k, bus.tx, bus.busy, bus.fifo_rd_en, bus.frame_done, fr[k/4], (k == 39));
                end
            end else if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
                bad++;
                $display("FAIL en_drop_idle k=%0d tx=%b busy=%b rd=%b expected 1 0 0",
                         k, bus.tx, bus.busy, bus.fifo_rd_en);
            end
        end
        total++;
        if (pops - p0 != 1) begin
            bad++;
            $display("FAIL en_drop_held pops=%0d expected 1", pops - p0);
        end
        bus.tx_en = 1'b1;
        #1;
        total++;
        if (bus.fifo_rd_en !== 1'b1) begin
            bad++;
            $display("FAIL en_resume_rd got=%b expected 1", bus.fifo_rd_en);
        end
        @(negedge clk);
        total++;
        if (bus.tx !== 1'b0 || bus.busy !== 1'b1 || pops - p0 != 2) begin
            bad++;
            $display("FAIL en_resume_start tx=%b busy=%b pops=%0d expected 0 1 2",
                     bus.tx, bus.busy, pops - p0);
        end
        n = 0;
        while (bus.busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.busy !== 1'b0 || pops - p0 != 2 || bus.fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL en_drain busy=%b pops=%0d empty=%b cycles=%0d expected 0 2 1",
                     bus.busy, pops - p0, bus.fifo_empty, n);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] fr;
        int p0;
        fr = {1'b1, 8'h5A, 1'b0};
        p0 = pops;
        mem[wr_ptr[5:0]] = 8'hC3;
        mem[(wr_ptr + 1) % 64] = 8'h5A;
        wr_ptr += 2;
        repeat (10) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy_before got=%b expected 1", bus.busy);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_async tx=%b busy=%b rd=%b expected 1 0 0",
                     bus.tx, bus.busy, bus.fifo_rd_en);
        end
        repeat (3) @(negedge clk);
        total++;
        if (pops - p0 != 1) begin
            bad++;
            $display("FAIL mid_reset_pops got=%0d expected 1", pops - p0);
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus.fifo_rd_en !== 1'b1) begin
            bad++;
            $display("FAIL mid_release_rd got=%b expected 1", bus.fifo_rd_en);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            total++;
            if (bus.tx !== fr[k/4] || bus.busy !== 1'b1 || bus.frame_done !== (k == 39)) begin
                bad++;
                $display("FAIL mid_resume_frame k=%0d tx=%b busy=%b done=%b expected %b 1 %b",
                         k, bus.tx, bus.busy, bus.frame_done, fr[k/4], (k == 39));
            end
        end
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || pops - p0 != 2 || bus.fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL mid_end busy=%b pops=%0d empty=%b expected 0 2 1",
                     bus.busy, pops - p0, bus.fifo_empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_tx_en_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
